// File: rtl/systolic_seq_pkg.sv
// Shared types and constants for the systolic tile sequencer: FSM states, command payload, tile sizing.
package systolic_seq_pkg;

   localparam int unsigned SEQ_DIM    = 8;
   localparam int unsigned SEQ_DATA_W = 16;
   localparam int unsigned SEQ_EB     = SEQ_DATA_W / 8;
   localparam int unsigned TILE_BYTES = SEQ_DIM * SEQ_DIM * SEQ_EB;
   localparam int unsigned ADDR_W     = 64;
   localparam int unsigned K_W        = 20;
   localparam int unsigned TCNT_W     = 8;
   localparam int unsigned LEN_W      = 34;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_START,
      ST_RUN,
      ST_FLUSH,
      ST_RESP
   } seq_state_e;

   // act_addr and out_addr double as the running tile pointers once latched
   typedef struct packed {
      logic [ADDR_W-1:0] act_addr;
      logic [ADDR_W-1:0] wgt_addr;
      logic [ADDR_W-1:0] out_addr;
      logic [ADDR_W-1:0] act_stride;
      logic [ADDR_W-1:0] wgt_stride;
      logic [K_W-1:0]    k;
      logic [TCNT_W-1:0] m;
      logic [TCNT_W-1:0] n;
   } seq_cmd_t;

   function automatic int unsigned tile_bytes(input int unsigned dim, input int unsigned data_bits);
      return dim * dim * (data_bits / 8);
   endfunction

endpackage

// File: rtl/stream_req_issuer.sv
// Holds one stream request valid until it fires, remembering the fire until cleared.
module stream_req_issuer (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clear_i,
   input  logic ready_i,
   output logic valid_c_o,
   output logic issued_c_o
);

   logic issued_q;
   logic issued_d;
   logic fire_c;

   assign valid_c_o  = en_i && !issued_q;
   assign fire_c     = valid_c_o && ready_i;
   assign issued_c_o = issued_q || fire_c;

   always_comb begin
      issued_d = issued_q;
      if (clear_i) begin
         issued_d = 1'b0;
      end else if (fire_c) begin
         issued_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         issued_q <= 1'b0;
      end else begin
         issued_q <= issued_d;
      end
   end

endmodule

// File: rtl/systolic_tile_sequencer.sv
// Walks an M x N grid of output tiles row-major, issuing act/wgt/out stream requests and
// an array start per tile, then answers the command with a tile count and error flag.
module systolic_tile_sequencer
   import systolic_seq_pkg::*;
#(
   parameter int unsigned SYSTOLIC_ARRAY_DIM = SEQ_DIM,
   parameter int unsigned DATA_WIDTH_BITS    = SEQ_DATA_W,
   parameter int unsigned INNER_DIM_BITS     = K_W,
   parameter int unsigned TILE_CNT_BITS      = TCNT_W,
   parameter int unsigned ADDR_BITS          = ADDR_W,
   parameter int unsigned LEN_BITS           = LEN_W
) (
   input  logic                        clock,
   input  logic                        areset,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic [ADDR_BITS-1:0]        cmd_act_addr,
   input  logic [ADDR_BITS-1:0]        cmd_wgt_addr,
   input  logic [ADDR_BITS-1:0]        cmd_out_addr,
   input  logic [ADDR_BITS-1:0]        cmd_act_stride,
   input  logic [ADDR_BITS-1:0]        cmd_wgt_stride,
   input  logic [INNER_DIM_BITS-1:0]   cmd_inner_dimension,
   input  logic [TILE_CNT_BITS-1:0]    cmd_m_tiles,
   input  logic [TILE_CNT_BITS-1:0]    cmd_n_tiles,
   output logic                        act_req_valid,
   input  logic                        act_req_ready,
   output logic [ADDR_BITS-1:0]        act_req_addr,
   output logic [LEN_BITS-1:0]         act_req_len,
   output logic                        wgt_req_valid,
   input  logic                        wgt_req_ready,
   output logic [ADDR_BITS-1:0]        wgt_req_addr,
   output logic [LEN_BITS-1:0]         wgt_req_len,
   output logic                        out_req_valid,
   input  logic                        out_req_ready,
   output logic [ADDR_BITS-1:0]        out_req_addr,
   output logic [LEN_BITS-1:0]         out_req_len,
   output logic                        sa_start_valid,
   input  logic                        sa_start_ready,
   output logic [INNER_DIM_BITS-1:0]   sa_inner_dimension,
   input  logic                        write_isFlushed,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [2*TILE_CNT_BITS-1:0]  resp_tiles_done,
   output logic                        resp_error
);

   localparam int unsigned EB_L        = DATA_WIDTH_BITS / 8;
   localparam int unsigned TILE_B      = tile_bytes(SYSTOLIC_ARRAY_DIM, DATA_WIDTH_BITS);
   localparam int unsigned STREAM_UNIT = SYSTOLIC_ARRAY_DIM * EB_L;
   localparam int unsigned TD_W        = 2 * TILE_CNT_BITS;

   seq_state_e           state_q, state_d;
   seq_cmd_t             cmd_q, cmd_d;
   logic [ADDR_BITS-1:0] wgt_ptr_q, wgt_ptr_d;
   logic [TCNT_W-1:0]    i_q, i_d;
   logic [TCNT_W-1:0]    j_q, j_d;
   logic [TD_W-1:0]      tiles_q, tiles_d;
   logic [LEN_BITS-1:0]  len_q, len_d;
   logic                 err_q, err_d;
   logic                 run_armed_q, run_armed_d;

   logic issue_en_c;
   logic act_done_c, wgt_done_c, out_done_c;
   logic cmd_fire_c;
   logic last_col_c, last_row_c;

   assign issue_en_c = (state_q == ST_ISSUE);

   stream_req_issuer u_act_iss (
      .clk_i(clock), .rst_i(areset), .en_i(issue_en_c), .clear_i(!issue_en_c),
      .ready_i(act_req_ready), .valid_c_o(act_req_valid), .issued_c_o(act_done_c)
   );

   stream_req_issuer u_wgt_iss (
      .clk_i(clock), .rst_i(areset), .en_i(issue_en_c), .clear_i(!issue_en_c),
      .ready_i(wgt_req_ready), .valid_c_o(wgt_req_valid), .issued_c_o(wgt_done_c)
   );

   stream_req_issuer u_out_iss (
      .clk_i(clock), .rst_i(areset), .en_i(issue_en_c), .clear_i(!issue_en_c),
      .ready_i(out_req_ready), .valid_c_o(out_req_valid), .issued_c_o(out_done_c)
   );

   assign cmd_ready      = (state_q == ST_IDLE) && !areset;
   assign cmd_fire_c     = cmd_valid && cmd_ready;
   assign sa_start_valid = (state_q == ST_START);
   assign resp_valid     = (state_q == ST_RESP);

   assign act_req_addr       = ADDR_BITS'(cmd_q.act_addr);
   assign wgt_req_addr       = wgt_ptr_q;
   assign out_req_addr       = ADDR_BITS'(cmd_q.out_addr);
   assign act_req_len        = len_q;
   assign wgt_req_len        = len_q;
   assign out_req_len        = LEN_BITS'(TILE_B);
   assign sa_inner_dimension = INNER_DIM_BITS'(cmd_q.k);
   assign resp_tiles_done    = tiles_q;
   assign resp_error         = err_q;

   assign last_col_c = (j_q == cmd_q.n - TCNT_W'(1));
   assign last_row_c = (i_q == cmd_q.m - TCNT_W'(1));

   // Next-state and datapath updates
   always_comb begin
      state_d     = state_q;
      cmd_d       = cmd_q;
      wgt_ptr_d   = wgt_ptr_q;
      i_d         = i_q;
      j_d         = j_q;
      tiles_d     = tiles_q;
      len_d       = len_q;
      err_d       = err_q;
      run_armed_d = (state_q == ST_RUN);

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_fire_c) begin
               cmd_d.act_addr   = ADDR_W'(cmd_act_addr);
               cmd_d.wgt_addr   = ADDR_W'(cmd_wgt_addr);
               cmd_d.out_addr   = ADDR_W'(cmd_out_addr);
               cmd_d.act_stride = ADDR_W'(cmd_act_stride);
               cmd_d.wgt_stride = ADDR_W'(cmd_wgt_stride);
               cmd_d.k          = K_W'(cmd_inner_dimension);
               cmd_d.m          = TCNT_W'(cmd_m_tiles);
               cmd_d.n          = TCNT_W'(cmd_n_tiles);
               wgt_ptr_d        = cmd_wgt_addr;
               i_d              = '0;
               j_d              = '0;
               tiles_d          = '0;
               len_d            = LEN_BITS'(cmd_inner_dimension) * LEN_BITS'(STREAM_UNIT);
               if ((cmd_inner_dimension == '0) || (cmd_m_tiles == '0) || (cmd_n_tiles == '0)) begin
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  err_d   = 1'b0;
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (act_done_c && wgt_done_c && out_done_c) begin
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (sa_start_ready) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // The array's idle flag is stale in the first RUN cycle, so it is masked there
            if (run_armed_q && sa_start_ready) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (write_isFlushed) begin
               tiles_d = tiles_q + TD_W'(1);
               if (last_row_c && last_col_c) begin
                  state_d = ST_RESP;
               end else begin
                  state_d        = ST_ISSUE;
                  cmd_d.out_addr = cmd_q.out_addr + ADDR_W'(TILE_B);
                  if (last_col_c) begin
                     j_d            = '0;
                     i_d            = i_q + TCNT_W'(1);
                     cmd_d.act_addr = cmd_q.act_addr + cmd_q.act_stride;
                     wgt_ptr_d      = ADDR_BITS'(cmd_q.wgt_addr);
                  end else begin
                     j_d       = j_q + TCNT_W'(1);
                     wgt_ptr_d = wgt_ptr_q + ADDR_BITS'(cmd_q.wgt_stride);
                  end
               end
            end
         end
         ST_RESP: begin
            if (resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (areset) begin
         state_q     <= ST_IDLE;
         cmd_q       <= '0;
         wgt_ptr_q   <= '0;
         i_q         <= '0;
         j_q         <= '0;
         tiles_q     <= '0;
         len_q       <= '0;
         err_q       <= 1'b0;
         run_armed_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         wgt_ptr_q   <= wgt_ptr_d;
         i_q         <= i_d;
         j_q         <= j_d;
         tiles_q     <= tiles_d;
         len_q       <= len_d;
         err_q       <= err_d;
         run_armed_q <= run_armed_d;
      end
   end

endmodule
